// File: rtl/tcm_port_arbiter_if.sv
// Bundle of the fetch port, data port and RAM-side signals around tcm_port_arbiter.
// Handshake: a port's request is consumed in the cycle its accept is high; its response follows exactly one cycle later with no back-pressure.
interface tcm_port_arbiter_if #(
    parameter int unsigned MEM_WORDS_W = 14
);
    logic                   mem_i_rd_i;
    logic [31:0]            mem_i_pc_i;
    logic                   mem_i_accept_o;
    logic                   mem_i_valid_o;
    logic                   mem_i_error_o;
    logic [31:0]            mem_i_inst_o;

    logic [31:0]            mem_d_addr_i;
    logic [31:0]            mem_d_data_wr_i;
    logic                   mem_d_rd_i;
    logic [3:0]             mem_d_wr_i;
    logic [10:0]            mem_d_req_tag_i;
    logic                   mem_d_accept_o;
    logic                   mem_d_ack_o;
    logic                   mem_d_error_o;
    logic [31:0]            mem_d_data_rd_o;
    logic [10:0]            mem_d_resp_tag_o;

    logic                   ram_en_o;
    logic [3:0]             ram_wr_o;
    logic [MEM_WORDS_W-1:0] ram_addr_o;
    logic [31:0]            ram_data_wr_o;
    logic [31:0]            ram_data_rd_i;

    modport slave (
        input  mem_i_rd_i, mem_i_pc_i,
        output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_req_tag_i,
        output mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o, mem_d_resp_tag_o,
        output ram_en_o, ram_wr_o, ram_addr_o, ram_data_wr_o,
        input  ram_data_rd_i
    );

    modport master (
        output mem_i_rd_i, mem_i_pc_i,
        input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
        output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_req_tag_i,
        input  mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o, mem_d_resp_tag_o,
        input  ram_en_o, ram_wr_o, ram_addr_o, ram_data_wr_o,
        output ram_data_rd_i
    );
endinterface

// File: rtl/tcm_port_arbiter.sv
// Shares a single-port TCM between the core's fetch and data ports, one access per cycle, responses one cycle later.
// Optional TCM_ARB_DPRIO_EN: data-priority arbitration with a fetch starvation limit (default: round-robin).
module tcm_port_arbiter #(
    parameter int unsigned MEM_WORDS_W  = 14,
    parameter logic [31:0] BASE_ADDR    = 32'h80000000,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    tcm_port_arbiter_if.slave  bus
);
    localparam logic [32:0] RAM_BYTES = 33'd4 << MEM_WORDS_W;

    logic        i_pend;
    logic        d_pend;
    logic        d_is_wr;
    logic        pick_d;
    logic        grant_i;
    logic        grant_d;
    logic [31:0] i_off;
    logic [31:0] d_off;
    logic        i_ok;
    logic        d_ok;

    logic        resp_i_q;
    logic        resp_d_q;
    logic        err_q;
    logic        wr_q;
    logic [10:0] tag_q;

`ifdef TCM_ARB_DPRIO_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
`else
    logic last_d_q;
    logic last_d_d;
    logic unused_limit;
    assign unused_limit = (STARVE_LIMIT != 0);
`endif

    always_comb begin
        i_pend  = bus.mem_i_rd_i;
        d_is_wr = |bus.mem_d_wr_i;
        d_pend  = bus.mem_d_rd_i | d_is_wr;
`ifdef TCM_ARB_DPRIO_EN
        // Data wins contention until it has starved a waiting fetch STARVE_LIMIT times.
        pick_d  = (starve_q < STARVE_W'(STARVE_LIMIT));
`else
        pick_d  = ~last_d_q;
`endif
        grant_d = ~rst_i & d_pend & (~i_pend | pick_d);
        grant_i = ~rst_i & i_pend & (~d_pend | ~pick_d);

        // Wrapping subtraction maps addresses below the base far out of range.
        i_off = bus.mem_i_pc_i - BASE_ADDR;
        d_off = bus.mem_d_addr_i - BASE_ADDR;
        i_ok  = ({1'b0, i_off} < RAM_BYTES) && (bus.mem_i_pc_i[1:0] == 2'b00);
        d_ok  = ({1'b0, d_off} < RAM_BYTES);
    end

    always_comb begin
        bus.ram_en_o      = 1'b0;
        bus.ram_wr_o      = 4'b0000;
        bus.ram_addr_o    = '0;
        bus.ram_data_wr_o = 32'h0;
        if (grant_i && i_ok) begin
            bus.ram_en_o   = 1'b1;
            bus.ram_addr_o = i_off[MEM_WORDS_W+1:2];
        end else if (grant_d && d_ok) begin
            bus.ram_en_o      = 1'b1;
            bus.ram_addr_o    = d_off[MEM_WORDS_W+1:2];
            bus.ram_wr_o      = bus.mem_d_wr_i;
            bus.ram_data_wr_o = bus.mem_d_data_wr_i;
        end
    end

`ifdef TCM_ARB_DPRIO_EN
    always_comb begin
        starve_d = starve_q;
        if (grant_i || !i_pend) begin
            starve_d = '0;
        end else if (grant_d) begin
            starve_d = starve_q + 1'b1;
        end
    end
`else
    always_comb begin
        last_d_d = last_d_q;
        if (grant_i || grant_d) begin
            last_d_d = grant_d;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_i_q <= 1'b0;
            resp_d_q <= 1'b0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            tag_q    <= 11'd0;
`ifdef TCM_ARB_DPRIO_EN
            starve_q <= '0;
`else
            last_d_q <= 1'b0;
`endif
        end else begin
            resp_i_q <= grant_i;
            resp_d_q <= grant_d;
            err_q    <= (grant_i & ~i_ok) | (grant_d & ~d_ok);
            wr_q     <= grant_d & d_is_wr;
            tag_q    <= grant_d ? bus.mem_d_req_tag_i : 11'd0;
`ifdef TCM_ARB_DPRIO_EN
            starve_q <= starve_d;
`else
            last_d_q <= last_d_d;
`endif
        end
    end

    // Responses are masked while reset is high so nothing granted just before reset leaks out.
    always_comb begin
        bus.mem_i_accept_o   = grant_i;
        bus.mem_d_accept_o   = grant_d;
        bus.mem_i_valid_o    = resp_i_q & ~rst_i;
        bus.mem_i_error_o    = resp_i_q & ~rst_i & err_q;
        bus.mem_i_inst_o     = (resp_i_q & ~rst_i & ~err_q) ? bus.ram_data_rd_i : 32'h0;
        bus.mem_d_ack_o      = resp_d_q & ~rst_i;
        bus.mem_d_error_o    = resp_d_q & ~rst_i & err_q;
        bus.mem_d_data_rd_o  = (resp_d_q & ~rst_i & ~err_q & ~wr_q) ? bus.ram_data_rd_i : 32'h0;
        bus.mem_d_resp_tag_o = (resp_d_q & ~rst_i) ? tag_q : 11'd0;
    end
endmodule
